parallel_to_serial: RTL and testbench

- Converts a width-bit parallel word into a serial bit stream, LSB first. The stream is compatible with the team's serial_to_parallel receiver, which reassembles the word exactly.
- Parallel side uses a valid/ready handshake. Serial side uses valid/ready with backpressure and a last-bit marker.
- One-word holding buffer behind the shifter lets back-to-back words stream with no idle cycle between them.
- Sits at the transmit end of serial links and test harnesses, feeding serial_to_parallel directly.

---
 rtl/parallel_to_serial.sv | 75 +++++++
 tb/tb_parallel_to_serial.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/parallel_to_serial.sv
// parallel_to_serial: turns a width-bit word into an LSB-first bit stream.
// Ports: clk/rst (sync, active-high); parallel_valid/ready/data in;
// serial_valid/data/last out with serial_ready backpressure.
module parallel_to_serial #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parallel_valid,
  input  logic [width-1:0] parallel_data,
  output logic             parallel_ready,
  output logic             serial_valid,
  output logic             serial_data,
  input  logic             serial_ready,
  output logic             serial_last
);

  localparam int CW = (width > 2) ? $clog2(width) : 1;
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  logic [width-1:0] r_shifter;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic [width-1:0] r_buf_data;
  logic             r_buf_valid;

  logic w_accept;
  logic w_xfer;
  logic w_done;

  // Outputs are masked by rst so they read 0 for the whole reset cycle.
  assign parallel_ready = !rst && !r_buf_valid;
  assign serial_valid   = !rst && r_busy;
  assign serial_data    = serial_valid && r_shifter[0];
  assign serial_last    = serial_valid && (r_cnt == LAST);

  assign w_accept = parallel_valid && parallel_ready;
  assign w_xfer   = serial_valid && serial_ready;
  assign w_done   = w_xfer && serial_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shifter   <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_buf_data  <= '0;
      r_buf_valid <= 1'b0;
    end else begin
      if (w_xfer && !w_done) begin
        r_shifter <= {1'b0, r_shifter[width-1:1]};
        r_cnt     <= r_cnt + 1'b1;
      end else if (w_done && r_buf_valid) begin
        r_shifter   <= r_buf_data;
        r_cnt       <= '0;
        r_buf_valid <= 1'b0;
      end else if (w_done && w_accept) begin
        // Buffer empty: the new word goes straight into the shifter.
        r_shifter <= parallel_data;
        r_cnt     <= '0;
      end else if (w_done) begin
        r_busy <= 1'b0;
      end else if (!r_busy && w_accept) begin
        r_shifter <= parallel_data;
        r_cnt     <= '0;
        r_busy    <= 1'b1;
      end

      if (r_busy && w_accept && !w_done) begin
        r_buf_data  <= parallel_data;
        r_buf_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// tb_parallel_to_serial: random and directed stimulus checked against a
// queue-of-words model of the expected LSB-first stream.
module tb_parallel_to_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         parallel_valid = 1'b0;
  logic [W-1:0] parallel_data = '0;
  logic         parallel_ready;
  logic         serial_valid;
  logic         serial_data;
  logic         serial_ready = 1'b0;
  logic         serial_last;

  parallel_to_serial #(.width(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .parallel_valid (parallel_valid),
    .parallel_data  (parallel_data),
    .parallel_ready (parallel_ready),
    .serial_valid   (serial_valid),
    .serial_data    (serial_data),
    .serial_ready   (serial_ready),
    .serial_last    (serial_last)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_ok  = 0;

  logic [W-1:0] tx[$];
  logic [W-1:0] q[$];
  int           bi = 0;
  int           phase = 0;
  int           bits = 0;
  int           lasts = 0;
  logic [W-1:0] rxw = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cycle(input bit r, input int mode);
    logic         pv;
    logic [W-1:0] pd;
    logic         sr;
    logic         w;
    bit           acc;
    bit           xf;
    @(negedge clk);
    rst = r;
    pv = !r && tx.size() > 0 && (mode != 2 || $urandom_range(0, 3) != 0);
    pd = pv ? tx[0] : W'($urandom);
    case (mode)
      1:       sr = (phase % 3 == 0);
      2:       sr = 1'($urandom_range(0, 1));
      default: sr = 1'b1;
    endcase
    phase++;
    parallel_valid = pv;
    parallel_data  = pd;
    serial_ready   = sr;
    #1;
    if (r) begin
      chk("rst_pready", parallel_ready, 0);
      chk("rst_svalid", serial_valid, 0);
      chk("rst_sdata", serial_data, 0);
      chk("rst_slast", serial_last, 0);
      q.delete();
      tx.delete();
      bi = 0;
      return;
    end
    w = q.size() > 0 ? q[0][bi] : 1'b0;
    chk("pready", parallel_ready, q.size() < 2);
    chk("svalid", serial_valid, q.size() > 0);
    chk("sdata", serial_data, w);
    chk("slast", serial_last, q.size() > 0 && bi == W - 1);
    acc = pv && parallel_ready;
    xf  = serial_valid && sr;
    if (xf && q.size() > 0) begin
      rxw[bi] = serial_data;
      bits++;
      if (serial_last) lasts++;
      bi++;
      if (bi == W) begin
        chk("word", rxw, q[0]);
        void'(q.pop_front());
        bi = 0;
      end
    end
    if (acc) begin
      q.push_back(pd);
      void'(tx.pop_front());
    end
  endtask

  task automatic run(input int mode, input int budget);
    int n = 0;
    while ((tx.size() > 0 || q.size() > 0) && n < budget) begin
      cycle(0, mode);
      n++;
    end
    chk("drain", tx.size() + q.size(), 0);
    cycle(0, mode);
  endtask

  initial begin
    int b0;
    cycle(1, 0);
    cycle(1, 0);
    cycle(0, 0);

    tx = '{8'hA5};
    b0 = bits;
    run(0, 40);
    chk("a5_bits", bits - b0, 8);

    tx = '{8'h01, 8'h80, 8'hFF};
    b0 = lasts;
    run(0, 60);
    chk("b2b_lasts", lasts - b0, 3);

    tx = '{8'h3C};
    run(1, 60);

    tx = '{8'h11, 8'h22, 8'h33};
    run(0, 60);

    tx = '{8'h5A, 8'h77};
    b0 = bits;
    for (int i = 0; i < 20 && bits - b0 < 3; i++) cycle(0, 0);
    chk("mid_inflight", q.size(), 2);
    cycle(1, 0);
    cycle(0, 0);
    chk("post_rst_ready", parallel_ready, 1);
    tx = '{8'hC3};
    run(0, 40);

    for (int i = 0; i < 100; i++) tx.push_back(W'($urandom));
    b0 = bits;
    run(0, 2000);
    chk("loop_bits", bits - b0, 800);

    for (int i = 0; i < 60; i++) tx.push_back(W'($urandom));
    run(2, 4000);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
